// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: a WIDTH-bit ripple add split into
// STAGES registered slices, with a valid/ready handshake on both sides.
module pipelined_adder_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SLICE = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // stage registers: skewed operands, deskewed partial sum, carry into next slice
   logic [STAGES-1:0]            vld;
   logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
   logic [STAGES-1:0]            c_q;
   logic                         ovf_q;

   logic [STAGES:0]              rdy;
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nxt;
   logic [STAGES-1:0]            c_in, v_in, c_nxt;
   logic                         ovf_nxt;

   // a stage may load when it is empty or its contents move on this edge
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES-1; k >= 0; k--)
         rdy[k] = !vld[k] || rdy[k+1];
   end

   always_comb begin
      a_in    = '0;
      b_in    = '0;
      s_in    = '0;
      c_in    = '0;
      v_in    = '0;
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub | cin;
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         s_in[k] = s_q[k-1];
         c_in[k] = c_q[k-1];
         v_in[k] = vld[k-1];
      end
   end

   always_comb begin
      logic [SLICE:0] part;
      part  = '0;
      s_nxt = s_in;
      c_nxt = '0;
      for (int k = 0; k < STAGES; k++) begin
         part = {1'b0, a_in[k][k*SLICE +: SLICE]} + {1'b0, b_in[k][k*SLICE +: SLICE]}
              + (SLICE+1)'(c_in[k]);
         s_nxt[k][k*SLICE +: SLICE] = part[SLICE-1:0];
         c_nxt[k] = part[SLICE];
      end
   end

   // the MSB slice lives in the last stage, so overflow is resolved there
   assign ovf_nxt = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                    (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               vld[k] <= v_in[k];
               if (v_in[k]) begin
                  a_q[k] <= a_in[k];
                  b_q[k] <= b_in[k];
                  s_q[k] <= s_nxt[k];
                  c_q[k] <= c_nxt[k];
               end
            end
         end
         if (rdy[LAST] && v_in[LAST])
            ovf_q <= ovf_nxt;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: three configurations share one stimulus stream,
// each tracked by its own arithmetic scoreboard.
module tb_pipelined_adder_sub;
   logic        clk, rst, in_valid, out_ready, cin, sub;
   logic [15:0] a, b;

   logic        rdy0, val0, co0, ov0, rdy1, val1, co1, ov1, rdy2, val2, co2, ov2;
   logic [15:0] s0, s1;
   logic [7:0]  s2;

   pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(val0), .out_ready(out_ready), .sum(s0),
      .cout(co0), .ovf(ov0));
   pipelined_adder_sub #(.WIDTH(16), .STAGES(1)) d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(val1), .out_ready(out_ready), .sum(s1),
      .cout(co1), .ovf(ov1));
   pipelined_adder_sub #(.WIDTH(8), .STAGES(8)) d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a[7:0]), .b(b[7:0]),
      .cin(cin), .sub(sub), .out_valid(val2), .out_ready(out_ready), .sum(s2),
      .cout(co2), .ovf(ov2));

   logic        o_rdy[3], o_val[3], o_cout[3], o_ovf[3];
   logic [15:0] o_sum[3];
   assign o_rdy[0] = rdy0;  assign o_val[0] = val0;  assign o_cout[0] = co0;
   assign o_rdy[1] = rdy1;  assign o_val[1] = val1;  assign o_cout[1] = co1;
   assign o_rdy[2] = rdy2;  assign o_val[2] = val2;  assign o_cout[2] = co2;
   assign o_ovf[0] = ov0;   assign o_ovf[1] = ov1;   assign o_ovf[2] = ov2;
   assign o_sum[0] = s0;    assign o_sum[1] = s1;    assign o_sum[2] = {8'h00, s2};

   int wid[3] = '{16, 16, 8};
   int stg[3] = '{4, 1, 8};

   logic [17:0] sq[3][$];
   int          pop_cnt[3];
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Plain integer arithmetic: {ovf, cout, sum} of a + (sub ? -b : b + cin) at w bits.
   function automatic logic [17:0] model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
      longint mask, half, av, bv, c0, full, sa, sb, r;
      logic [15:0] rs;
      logic rc, ro;
      mask = (64'sd1 <<< w) - 1;
      half = 64'sd1 <<< (w - 1);
      av   = longint'(ma) & mask;
      bv   = longint'(mb) & mask;
      if (ms) bv = (~bv) & mask;
      c0   = ms ? 64'sd1 : longint'(mc);
      full = av + bv + c0;
      rs   = 16'(full & mask);
      rc   = ((full >>> w) & 64'sd1) != 0;
      sa   = (av >= half) ? av - (mask + 1) : av;
      sb   = (bv >= half) ? bv - (mask + 1) : bv;
      r    = sa + sb + c0;
      ro   = (r >= half) || (r < -half);
      return {ro, rc, rs};
   endfunction

   // one compare process for all three instances
   always @(negedge clk) begin
      if (rst) begin
         for (int j = 0; j < 3; j++) sq[j].delete();
      end else begin
         for (int j = 0; j < 3; j++) begin
            chk($sformatf("in_ready[%0d]", j), 32'(o_rdy[j]),
                32'(!(sq[j].size() == stg[j] && !out_ready)));
            if (o_val[j]) begin
               if (sq[j].size() == 0) begin
                  chk($sformatf("spurious_out[%0d]", j), 32'(o_val[j]), 32'd0);
               end else begin
                  chk($sformatf("result[%0d]", j), {14'd0, o_ovf[j], o_cout[j], o_sum[j]},
                      {14'd0, sq[j][0]});
                  if (out_ready) begin
                     void'(sq[j].pop_front());
                     pop_cnt[j]++;
                  end
               end
            end
            if (in_valid && o_rdy[j]) sq[j].push_back(model(wid[j], a, b, cin, sub));
         end
      end
   end

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic ts, input logic [15:0] es, input logic ec,
                         input logic eo, input string nm);
      int n;
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!o_val[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'd3);
      chk({nm, "_value"}, {14'd0, o_ovf[0], o_cout[0], o_sum[0]}, {14'd0, eo, ec, es});
      @(posedge clk); #1;
   endtask

   initial begin
      int lowc, base, i, cyc, n, tot;
      logic acc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      for (int j = 0; j < 3; j++) pop_cnt[j] = 0;
      #12;
      chk("rst_out_valid", 32'(o_val[0]), 32'd0);
      chk("rst_in_ready", 32'(o_rdy[0]), 32'd1);
      chk("rst_sum", 32'(o_sum[0]), 32'd0);
      #11 rst = 1'b0;
      @(posedge clk); #1;

      // directed arithmetic with hand-computed results
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_ffff");
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin_ignored");
      run_op(16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, "add_cin");
      chk("model_pin", 32'(model(8, 16'h00FF, 16'h0001, 1'b0, 1'b0)), 32'h10000);

      // backpressure: 8 back-to-back ops, out_ready low for 3 cycles once the pipe is full
      lowc = 0; base = pop_cnt[0]; i = 0; cyc = 0;
      while (i < 8 && cyc < 60) begin
         a = 16'h1111 * 16'(i); b = 16'h0F0F + 16'(i); cin = i[0]; sub = i[1];
         in_valid = 1'b1;
         out_ready = !(cyc >= 4 && cyc < 7);
         @(negedge clk);
         acc = o_rdy[0];
         if (!acc) lowc++;
         @(posedge clk); #1;
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (sq[0].size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_in_ready_low_cycles", 32'(lowc), 32'd3);
      chk("bp_result_count", 32'(pop_cnt[0] - base), 32'd8);

      // reset with three operations in flight
      for (int k = 0; k < 3; k++) begin
         a = 16'h0100 * 16'(k + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #3;
      chk("pre_rst_out_valid", 32'(o_val[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(o_val[0]), 32'd0);
      chk("async_rst_sum", 32'(o_sum[0]), 32'd0);
      chk("async_rst_cout", 32'(o_cout[0]), 32'd0);
      chk("async_rst_ovf", 32'(o_ovf[0]), 32'd0);
      chk("async_rst_in_ready", 32'(o_rdy[0]), 32'd1);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", 32'(o_val[0]), 32'd0);
      end
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst_op");

      // random traffic with random backpressure on all three configurations
      for (int k = 0; k < 10000; k++) begin
         a = 16'($urandom); b = 16'($urandom);
         if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) b = 16'h8000;
         cin = 1'($urandom); sub = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      tot = sq[0].size() + sq[1].size() + sq[2].size();
      while (tot != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
         tot = sq[0].size() + sq[1].size() + sq[2].size();
      end
      chk("drain_outstanding", 32'(tot), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_adder_sub.md
# pipelined_adder_sub

Parametrised, pipelined two's-complement adder/subtractor: the next-generation arithmetic slice of our adder family. Breaks a WIDTH-bit ripple-carry add into STAGES registered slices, so a wide add closes timing at full clock rate with a throughput of one operation per cycle. Adds subtract mode, carry-out, signed overflow and a valid/ready handshake on both sides, so it drops directly into streaming datapaths.

## Interface
- WIDTH, 32: operand/result width in bits; must be ≥ 1.
- STAGES, 4: pipeline depth. WIDTH % STAGES == 0 is required; SLICE = WIDTH/STAGES bits per stage. STAGES = 1 gives a single registered adder.

Ports (reset is asynchronous and active-high; one clock):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub = 1.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode this is the inverted borrow: 1 = no borrow.
- ovf  output  1  signed overflow.

## Operation
- Arithmetic:
  - Let b' = sub ? ~b : b and c0 = sub ? 1 : cin.
  - {cout, sum} = a + b' + c0, computed at WIDTH+1 bits.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
- Slicing:
  - Stage k adds bits [k·SLICE +: SLICE] using the carry registered by stage k-1. Stage 0 uses c0.
  - Operand slices not yet consumed travel with the operation in skew registers.
  - Result slices already produced travel forward in deskew registers.
  - The final stage registers the complete sum, cout and ovf.
- Per-stage valid bit v[k], k = 0..STAGES-1; the last stage drives out_valid.
- Ready chain:
  - rdy[STAGES] = out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0].
- Stage k loads from stage k-1 (stage 0 loads from the inputs) when rdy[k] is 1. Its valid bit becomes the upstream valid.
- A transfer happens on a rising edge where valid && ready. Bubbles collapse, so the pipe holds up to STAGES operations.
- Results leave strictly in acceptance order. No operation is lost or duplicated.
- While out_valid && !out_ready, sum/cout/ovf stay stable.
- A stalled stage keeps its data and valid bit unchanged.
- in_ready is combinational from out_ready and the valid bits. It has no dependency on in_valid.

## Timing
- Reset (asynchronous assert): all v[k] = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, all internal data registers = 0. in_ready = 1 while rst is high and after release.
- rst is sampled asynchronously on assert. The first operation can be accepted on the first rising edge after rst deasserts.
- Latency: an operation accepted at edge T shows out_valid = 1 after edge T+STAGES-1 when no stall occurs. With STAGES = 1, the result is visible in the cycle after acceptance.
- Throughput: 1 operation per cycle while out_ready = 1.
- Simultaneous events:
  - A full pipe with out_ready = 1 accepts a new input on the same edge the oldest result leaves.
  - When out_ready = 0 and the pipe is full, in_ready = 0.
- Reset mid-operation: all in-flight operations are discarded. No stale result appears after release.
- Carry propagation: a carry generated in slice 0 reaches the MSB through every stage register. The full ripple must be correct, for example all-ones + 1.

## Test plan
All scenarios use WIDTH = 16, STAGES = 4 unless stated otherwise.
- Reset: assert rst mid-clock -> out_valid, sum, cout and ovf go to 0 immediately; in_ready = 1; no out_valid for 4 cycles after release when no input is driven.
- Full ripple: a = 0xFFFF, b = 0x0001, cin = 0, accepted at edge T -> out_valid at edge T+3, sum = 0x0000, cout = 1, ovf = 0. Then a = 0x7FFF, b = 0x0001 -> sum = 0x8000, ovf = 1, cout = 0.
- Subtract:
  - 0x0005 − 0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0.
  - 0x8000 − 0x0001 -> sum = 0x7FFF, cout = 1, ovf = 1.
  - With sub = 1 and cin = 1, cin is ignored.
- Backpressure: 8 back-to-back operations with out_ready = 0 for 3 cycles mid-stream -> in_ready drops only once 4 operations are held; sum stays stable while stalled; all 8 results emerge in order, none duplicated.
- Reset with 3 operations in flight -> nothing emerges after release; the next operation completes with normal latency.
- Random: 10k random a/b/cin/sub with random in_valid/out_ready, checked against a behavioural model -> zero mismatches. Repeat with (WIDTH = 16, STAGES = 1) and (WIDTH = 8, STAGES = 8).
